io_panel: RTL
=============

# io_panel

Host-side front panel for the DE1 accumulator processor. It sits between the board's switches, pushbutton and 7-segment displays and the processor's `dataIn`/`enter`/`dataOut`/`Halt`/`IR` interface, acting as the other end of the processor's input/output protocol. It debounces the enter key and snapshots the switches into `dataIn`. It then holds `enter` until the processor has consumed the input, and renders the processor's output byte on two hex digits.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 16: consecutive stable cycles required to accept a key change (board build overrides to 500000).
- `CNT_W`, default 20: debounce counter width; must hold `DEBOUNCE_CYCLES`.
- `IN_OPCODE`, default 3'b011: processor opcode of the input instruction.

Ports:
- `clock` in 1: single clock for all logic.
- `reset` in 1: synchronous, active-high.
- `sw` in 8: board switches, asynchronous.
- `key_n` in 1: enter pushbutton, active-low, asynchronous, bouncy.
- `IR` in 3: processor's current opcode.
- `Halt` in 1: processor halt flag.
- `cpuOut` in 8: processor `dataOut`.
- `dataIn` out 8: byte presented to the processor.
- `enter` out 1: input-valid level to the processor.
- `hex0` out 7: low nibble of `cpuOut`, active-low segments, bit6=g … bit0=a.
- `hex1` out 7: high nibble of `cpuOut`, same encoding.
- `ledHalt` out 1: registered copy of `Halt`.

## Operation
- **Synchronizers:** `key_n` and `sw` each pass through two flops (`key_s`, `sw_s`). Reset value: `key_s`=1, `sw_s`=0.
- **Debounce:**
  - Register `key_db` resets to 1 (released).
  - While `key_s != key_db`, the counter increments; when it reaches `DEBOUNCE_CYCLES`, `key_db` takes `key_s` and the counter clears.
  - Any cycle with `key_s == key_db` clears the counter.
- **Events:** `press` = `key_db` 1→0 and `release` = `key_db` 0→1. Each is a one-cycle strobe.
- **Enter FSM** (resets to IDLE):
  - IDLE: `enter`=0. On `press`, `dataIn` ← `sw_s` → ARMED.
  - ARMED: `enter`=1; flag `seen` ← 1 when `IR == IN_OPCODE`. When `seen`=1 and `IR != IN_OPCODE`, the input is accepted → WAIT_REL, and `enter` drops on that same transition edge.
  - WAIT_REL: `enter`=0. On `key_db`==1 (released) → IDLE.
  - Presses outside IDLE are ignored. `dataIn` changes only on an accepted `press`. If `release` occurs while still ARMED, the FSM stays ARMED; `enter` remains held until consumed.
  - `Halt`=1 while ARMED or WAIT_REL forces the FSM to WAIT_REL next cycle, so a stale `enter` is never left pending after a halt.
- **Output:**
  - `cpuOut` is registered every cycle into `out_q`.
  - `hex0`/`hex1` are registered decodes of `out_q[3:0]`/`out_q[7:4]` (0–9, A–F standard glyphs; e.g. 0→7'h40, 5→7'h12, A→7'h08, F→7'h0E).
  - `ledHalt` is `Halt` delayed one flop.
- **Reset values:** `dataIn`=0, `enter`=0, `hex0`=`hex1`=7'h40, `ledHalt`=0, counter=0, `seen`=0.

## Timing
- **Press to `enter`:** with `key_n` held low from the edge that first samples it low (edge 0), `enter` is 1 after edge `DEBOUNCE_CYCLES`+3.
- **Bounce:** any `key_n` glitch shorter than `DEBOUNCE_CYCLES` cycles produces no event.
- **Drop latency:** `enter` falls on the first edge at which `IR != IN_OPCODE` is sampled after `seen`.
- **Output path:** `cpuOut` to `hex*` is 2 cycles; `Halt` to `ledHalt` is 1 cycle.
- **Reset mid-operation:** `reset` asserted in any state returns everything to reset values on the next edge, regardless of `key_n`. If the key is still held low after reset, it is seen as a new press only after re-synchronizing from `key_db`=1, i.e. after `DEBOUNCE_CYCLES`+3 cycles.
- **Simultaneous events:** `press` and `Halt` in the same IDLE cycle take the press (→ARMED); the halt forces WAIT_REL on the following cycle.

## Structure
- Package `io_panel_pkg`:
  - FSM state enum (IDLE, ARMED, WAIT_REL);
  - default `IN_OPCODE`;
  - function `hex7seg(input [3:0]) → [6:0]` with the active-low glyph table.
- Sub-module `debounce` (parameters `DEBOUNCE_CYCLES`, `CNT_W`; ports `clock`, `reset`, `in_s`, `out_db`, `rise`, `fall`). It contains the counter and edge strobes and is instantiated once.
- The synchronizers, FSM and display registers live in `io_panel`.

## Test plan
- **Reset:** hold `reset` 3 cycles with `key_n`=0, `cpuOut`=8'hFF → during and one cycle after: `enter`=0, `dataIn`=0, `hex0`=`hex1`=7'h40.
- **Clean press:** `sw`=8'h5A, `key_n` low at cycle 0 → `enter`=1 after edge 19 with `dataIn`=8'h5A. Drive `IR`=3'b011 for 4 cycles then 3'b000 → `enter`=0 on that edge; release key → IDLE.
- **Bounce:** toggle `key_n` with 10-cycle low pulses ×5 (`DEBOUNCE_CYCLES`=16) → `enter` never rises, `dataIn` unchanged.
- **Second press ignored:** release and re-press while ARMED → `dataIn` keeps the first snapshot and `enter` stays 1 until consumption.
- **Halt while armed:** ARMED, `Halt`=1 → `enter`=0 next cycle, `ledHalt`=1; `key_n` release → IDLE.
- **Display:** `cpuOut`=8'hA5 → after 2 cycles `hex1`=7'h08, `hex0`=7'h12.

Source files
------------

// File: rtl/io_panel_pkg.sv
// io_panel_pkg: shared FSM state type, default input opcode and active-low 7-segment glyph decode
package io_panel_pkg;
  typedef enum logic [1:0] {IDLE, ARMED, WAIT_REL} state_e;
  localparam logic [2:0] IN_OPCODE_DEF = 3'b011;
  localparam logic [6:0] SEG [0:15] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  function automatic logic [6:0] hex7seg(input logic [3:0] d);
    return SEG[d];
  endfunction
endpackage

// File: rtl/io_panel_debounce.sv
// debounce: in_s (synchronized key) -> out_db level after DEBOUNCE_CYCLES+1 differing cycles, with rise/fall one-cycle strobes
module debounce #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W = 20
) (
  input  logic clock,
  input  logic reset,
  input  logic in_s,
  output logic out_db,
  output logic rise,
  output logic fall
);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(DEBOUNCE_CYCLES);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic db_q, db_d, prev_q;
  always_comb begin
    cnt_d = (in_s == db_q || cnt_q == LIMIT) ? '0 : cnt_q + 1'b1;
    db_d = (in_s != db_q && cnt_q == LIMIT) ? in_s : db_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
      db_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      db_q <= db_d;
      prev_q <= db_q;
    end
  end
  assign out_db = db_q;
  assign rise = ~prev_q & db_q;
  assign fall = prev_q & ~db_q;
endmodule

// File: rtl/io_panel.sv
// io_panel: front panel; in: clock, reset, sw, key_n, IR, Halt, cpuOut; out: dataIn/enter handshake to the CPU, hex0/hex1 display of cpuOut, ledHalt
module io_panel
  import io_panel_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W = 20,
  parameter logic [2:0] IN_OPCODE = IN_OPCODE_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] sw,
  input  logic       key_n,
  input  logic [2:0] IR,
  input  logic       Halt,
  input  logic [7:0] cpuOut,
  output logic [7:0] dataIn,
  output logic       enter,
  output logic [6:0] hex0,
  output logic [6:0] hex1,
  output logic       ledHalt
);
  logic key_m_q, key_s_q;
  logic [7:0] sw_m_q, sw_s_q;
  logic key_db, rise, fall;
  state_e state_q, state_d;
  logic seen_q, seen_d;
  logic [7:0] din_q, din_d;
  logic [7:0] out_q;
  logic [6:0] hex0_q, hex1_q;
  logic led_q;
  debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db (
    .clock(clock), .reset(reset), .in_s(key_s_q),
    .out_db(key_db), .rise(rise), .fall(fall)
  );
  always_comb begin
    state_d = state_q;
    seen_d = 1'b0;
    din_d = din_q;
    case (state_q)
      IDLE: if (fall) begin
        state_d = ARMED;
        din_d = sw_s_q;
      end
      ARMED: begin
        seen_d = seen_q | (IR == IN_OPCODE);
        if (Halt || (seen_q && IR != IN_OPCODE)) state_d = WAIT_REL;
      end
      WAIT_REL: if (key_db | rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      key_m_q <= 1'b1;
      key_s_q <= 1'b1;
      sw_m_q <= '0;
      sw_s_q <= '0;
      state_q <= IDLE;
      seen_q <= 1'b0;
      din_q <= '0;
      out_q <= '0;
      hex0_q <= 7'h40;
      hex1_q <= 7'h40;
      led_q <= 1'b0;
    end else begin
      key_m_q <= key_n;
      key_s_q <= key_m_q;
      sw_m_q <= sw;
      sw_s_q <= sw_m_q;
      state_q <= state_d;
      seen_q <= seen_d;
      din_q <= din_d;
      out_q <= cpuOut;
      hex0_q <= hex7seg(out_q[3:0]);
      hex1_q <= hex7seg(out_q[7:4]);
      led_q <= Halt;
    end
  end
  assign dataIn = din_q;
  assign enter = state_q == ARMED;
  assign hex0 = hex0_q;
  assign hex1 = hex1_q;
  assign ledHalt = led_q;
endmodule
